round_sequencer: RTL and testbench
==================================

# round_sequencer

Game-round controller that sequences the sprite/screen drawing datapath for the two-player cat/dog/chicken game. Collects each player's one-hot choice, issues draw requests for prompt, scenario and end screens over a req/done handshake, decides the round winner, and keeps saturating per-player scores until a match winner is reached. Sits between the KEY/SW user inputs and the datapath/VGA drawing pipeline, replacing ad-hoc scenario decode in the top level.

## Interface
- WIN_SCORE, 5: score that ends the match (1..9, shown on one HEX digit)
- SCORE_W, 4: score register width
- clk  in  1  system clock (CLOCK_50)
- resetn  in  1  asynchronous, active-low reset
- choice  in  3  player choice from SW[2:0]; cat=3'b001, dog=3'b010, chicken=3'b100
- choose  in  1  level, high while KEY[2] pressed; acts on rising edge
- cont  in  1  level, high while KEY[1] pressed; acts on rising edge
- reset_game  in  1  level, high while KEY[3] pressed; acts on rising edge
- draw_done  in  1  one-cycle pulse from datapath, current screen finished
- draw_req  out  1  request datapath draw of draw_scene
- draw_scene  out  4  screen id: 0-8 scenario (p1_idx*3+p2_idx, cat=0 dog=1 chicken=2), 9 title, 10 P1 prompt, 11 P2 prompt, 12 P1 wins match, 13 P2 wins match
- score1, score2  out  SCORE_W  player scores
- round_result  out  2  01 P1 won round, 10 P2 won, 00 tie/none
- match_over  out  1  high from end-screen request until restart

## Operation
- Rules: dog beats cat, cat beats chicken, chicken beats dog; equal choices tie.
- States: TITLE_DRAW -> WAIT_START (cont) -> P1_DRAW -> P1_PICK (choose with valid choice, latch p1) -> P2_DRAW -> P2_PICK (choose valid, latch p2) -> RES_DRAW -> SCORE (1 cycle) -> RES_WAIT (cont) -> P1_DRAW, or END_DRAW if a score == WIN_SCORE -> END_WAIT (cont) -> TITLE_DRAW with scores cleared.
- *_DRAW states: assert draw_req with draw_scene; leave on draw_done.
- Valid choice = exactly one bit set; choose with invalid choice ignored, state held.
- SCORE: increment winner's score, saturate at WIN_SCORE; set round_result; tie leaves scores.
- round_result cleared on entering P1_DRAW; match_over set on entering END_DRAW, cleared on entering TITLE_DRAW.
- reset_game edge sets pending flag; honoured at next cycle with no draw outstanding (draw_req low, or draw_done this cycle): scores, result, match_over cleared, go to TITLE_DRAW. reset_game wins over choose/cont in same cycle.
- Edges of choose/cont outside states that consume them are discarded (not queued).

## Timing
- Reset (async): state TITLE_DRAW, draw_req 0, draw_scene 0, scores 0, round_result 00, match_over 0, edge-detect history 0, pending 0.
- All outputs registered. draw_req rises 1st clk after resetn release, draw_scene = 9 same cycle.
- Handshake: draw_req/draw_scene stable until draw_done sampled high; draw_req low next cycle; next request's draw_req no earlier than cycle after that (≥1 low cycle between requests).
- draw_done while draw_req low: ignored.
- Input edge: detected in cycle k when input high at k and low at k-1; resulting state change at k; next draw_req high at k+1.
- Scores update at SCORE exit edge, visible same cycle RES_WAIT entered; draw of scenario precedes score change.

## Structure
- game_pkg: choice encodings, scene ids (SCN_TITLE etc.), state enum, choice-to-index function, beats() function.
- Sub-module edge_rise (registered rising-edge detector), instantiated for choose, cont, reset_game.

## Test plan
- Reset release -> draw_req=1, draw_scene=9 at cycle 1; done pulse -> draw_req=0 next cycle, no new req until cont edge.
- P1 dog, P2 cat -> scene 3, round_result 01, score1 1, score2 0; P1 cat, P2 cat -> scene 0, result 00, scores unchanged.
- choose with choice=3'b011 or 3'b000 in P1_PICK -> no transition, no draw_req; then 3'b100 -> scene 11 requested.
- P2 wins WIN_SCORE=5 rounds (chicken vs P1 dog) -> score2=5, after cont draw_scene=13, match_over=1; cont -> scene 9, scores 0.
- reset_game mid-draw of scene 10 -> draw_req held until draw_done, then scene 9 requested, scores cleared; simultaneous choose ignored.
- choose held high many cycles -> single latch; draw_done with draw_req low -> no state change.

Source files
------------

// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
//
// Shared definitions for the cat/dog/chicken round sequencer.
//   - one-hot player choice encodings (SW[2:0])
//   - screen ids understood by the drawing datapath
//   - round result encodings
//   - sequencer state enum
//   - helpers: choice validity, choice-to-index, beats(), scenario screen id,
//     and a draw-state classifier
// -----------------------------------------------------------------------------
package game_pkg;

  // Player choices as seen on SW[2:0].
  localparam logic [2:0] CH_CAT     = 3'b001;
  localparam logic [2:0] CH_DOG     = 3'b010;
  localparam logic [2:0] CH_CHICKEN = 3'b100;

  // Choice indices used to build scenario screen ids.
  localparam logic [1:0] IDX_CAT     = 2'd0;
  localparam logic [1:0] IDX_DOG     = 2'd1;
  localparam logic [1:0] IDX_CHICKEN = 2'd2;

  // Screen ids. 0..8 are scenario screens (p1_idx*3 + p2_idx).
  localparam logic [3:0] SCN_TITLE  = 4'd9;
  localparam logic [3:0] SCN_P1     = 4'd10;
  localparam logic [3:0] SCN_P2     = 4'd11;
  localparam logic [3:0] SCN_P1_WIN = 4'd12;
  localparam logic [3:0] SCN_P2_WIN = 4'd13;

  // Round result encodings.
  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;

  typedef enum logic [3:0] {
    ST_TITLE_DRAW = 4'd0,
    ST_WAIT_START = 4'd1,
    ST_P1_DRAW    = 4'd2,
    ST_P1_PICK    = 4'd3,
    ST_P2_DRAW    = 4'd4,
    ST_P2_PICK    = 4'd5,
    ST_RES_DRAW   = 4'd6,
    ST_SCORE      = 4'd7,
    ST_RES_WAIT   = 4'd8,
    ST_END_DRAW   = 4'd9,
    ST_END_WAIT   = 4'd10
  } state_t;

  // A choice is usable only when exactly one switch is up.
  function automatic logic choice_valid(input logic [2:0] c);
    logic v;
    case (c)
      CH_CAT, CH_DOG, CH_CHICKEN: v = 1'b1;
      default:                    v = 1'b0;
    endcase
    return v;
  endfunction

  function automatic logic [1:0] choice_idx(input logic [2:0] c);
    logic [1:0] idx;
    case (c)
      CH_DOG:     idx = IDX_DOG;
      CH_CHICKEN: idx = IDX_CHICKEN;
      default:    idx = IDX_CAT;
    endcase
    return idx;
  endfunction

  // True when choice index a beats choice index b:
  // dog beats cat, cat beats chicken, chicken beats dog.
  function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
    return ((a == IDX_DOG)     && (b == IDX_CAT))     ||
           ((a == IDX_CAT)     && (b == IDX_CHICKEN)) ||
           ((a == IDX_CHICKEN) && (b == IDX_DOG));
  endfunction

  // Scenario screen id = a*3 + b, built from shifts to stay in 4 bits.
  function automatic logic [3:0] scenario_id(input logic [1:0] a, input logic [1:0] b);
    logic [3:0] a4;
    a4 = {2'b00, a};
    return (a4 << 1) + a4 + {2'b00, b};
  endfunction

  function automatic logic is_draw_state(input state_t s);
    return (s == ST_TITLE_DRAW) || (s == ST_P1_DRAW) || (s == ST_P2_DRAW) ||
           (s == ST_RES_DRAW)   || (s == ST_END_DRAW);
  endfunction

endpackage

// File: rtl/edge_rise.sv
// -----------------------------------------------------------------------------
// edge_rise
//
// Rising-edge detector for a level input already synchronous to clk.
// The previous level is kept in a register; rise_o is high in the cycle where
// d_i is high and was low in the previous cycle.
//
// Ports
//   clk     in   system clock
//   resetn  in   asynchronous active-low reset (history cleared to 0)
//   d_i     in   level input
//   rise_o  out  one-cycle rising-edge indication
// -----------------------------------------------------------------------------
module edge_rise (
  input  logic clk,
  input  logic resetn,
  input  logic d_i,
  output logic rise_o
);

  logic hist_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= d_i;
    end
  end

  assign rise_o = d_i & ~hist_q;

endmodule

// File: rtl/round_sequencer.sv
// -----------------------------------------------------------------------------
// round_sequencer
//
// Game-round controller for the two-player cat/dog/chicken game. Collects each
// player's one-hot choice, requests prompt/scenario/end screens from the
// drawing datapath, decides each round and keeps saturating scores until one
// player reaches WIN_SCORE.
//
// Handshake (draw_req/draw_done): draw_req and draw_scene are held stable until
// draw_done is sampled high while draw_req is high; draw_req then drops in the
// next cycle and stays low for at least one cycle before any further request.
// draw_done while draw_req is low is ignored.
//
// Parameters
//   WIN_SCORE  score that ends the match (1..9)
//   SCORE_W    score register width
//
// Ports
//   clk           in   system clock
//   resetn        in   asynchronous active-low reset
//   choice[2:0]   in   player choice (cat 001, dog 010, chicken 100)
//   choose        in   level, acts on rising edge: latch current player's choice
//   cont          in   level, acts on rising edge: advance past wait screens
//   reset_game    in   level, acts on rising edge: restart at title screen
//   draw_done     in   one-cycle pulse, requested screen finished
//   draw_req      out  draw request
//   draw_scene    out  screen id for the current request
//   score1/score2 out  player scores
//   round_result  out  01 P1 won round, 10 P2 won, 00 tie/none
//   match_over    out  high from end-screen request until restart
//   dbg_state     out  current sequencer state (game_pkg::state_t encoding)
// -----------------------------------------------------------------------------
module round_sequencer
  import game_pkg::*;
#(
  parameter int WIN_SCORE = 5,
  parameter int SCORE_W   = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [2:0]         choice,
  input  logic               choose,
  input  logic               cont,
  input  logic               reset_game,
  input  logic               draw_done,
  output logic               draw_req,
  output logic [3:0]         draw_scene,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [1:0]         round_result,
  output logic               match_over,
  output logic [3:0]         dbg_state
);

  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

  // Registered state and outputs
  state_t             state_q, state_d;
  logic [1:0]         p1_q, p1_d;
  logic [1:0]         p2_q, p2_d;
  logic [SCORE_W-1:0] s1_q, s1_d;
  logic [SCORE_W-1:0] s2_q, s2_d;
  logic [1:0]         rr_q, rr_d;
  logic               mo_q, mo_d;
  logic               req_q, req_d;
  logic [3:0]         scene_q, scene_d;
  logic               pend_q, pend_d;

  // Edge pulses
  logic choose_rise;
  logic cont_rise;
  logic rg_rise;

  // Handshake / reset helpers
  logic done_ok;
  logic draw_busy;
  logic reset_req;
  logic do_reset;

  edge_rise u_choose_edge (
    .clk    (clk),
    .resetn (resetn),
    .d_i    (choose),
    .rise_o (choose_rise)
  );

  edge_rise u_cont_edge (
    .clk    (clk),
    .resetn (resetn),
    .d_i    (cont),
    .rise_o (cont_rise)
  );

  edge_rise u_reset_edge (
    .clk    (clk),
    .resetn (resetn),
    .d_i    (reset_game),
    .rise_o (rg_rise)
  );

  // A draw is finished only when done arrives while a request is up.
  assign done_ok   = req_q & draw_done;
  // A draw is outstanding if the request is up and this cycle does not end it.
  assign draw_busy = req_q & ~draw_done;
  // A restart request waits in pend_q until no draw is outstanding.
  assign reset_req = pend_q | rg_rise;
  assign do_reset  = reset_req & ~draw_busy;

  always_comb begin
    state_d = state_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    rr_d    = rr_q;
    mo_d    = mo_q;
    scene_d = scene_q;
    pend_d  = reset_req & ~do_reset;

    if (do_reset) begin
      // Restart beats any choose/cont edge in the same cycle.
      state_d = ST_TITLE_DRAW;
      s1_d    = '0;
      s2_d    = '0;
      rr_d    = RES_NONE;
      mo_d    = 1'b0;
    end else begin
      case (state_q)
        ST_TITLE_DRAW: begin
          if (done_ok) state_d = ST_WAIT_START;
        end
        ST_WAIT_START: begin
          if (cont_rise) begin
            state_d = ST_P1_DRAW;
            rr_d    = RES_NONE;
          end
        end
        ST_P1_DRAW: begin
          if (done_ok) state_d = ST_P1_PICK;
        end
        ST_P1_PICK: begin
          if (choose_rise && choice_valid(choice)) begin
            p1_d    = choice_idx(choice);
            state_d = ST_P2_DRAW;
          end
        end
        ST_P2_DRAW: begin
          if (done_ok) state_d = ST_P2_PICK;
        end
        ST_P2_PICK: begin
          if (choose_rise && choice_valid(choice)) begin
            p2_d    = choice_idx(choice);
            state_d = ST_RES_DRAW;
          end
        end
        ST_RES_DRAW: begin
          if (done_ok) state_d = ST_SCORE;
        end
        ST_SCORE: begin
          // Scenario screen is already drawn; scores move only now.
          state_d = ST_RES_WAIT;
          if (beats(p1_q, p2_q)) begin
            rr_d = RES_P1;
            if (s1_q < WIN) s1_d = s1_q + SCORE_W'(1);
          end else if (beats(p2_q, p1_q)) begin
            rr_d = RES_P2;
            if (s2_q < WIN) s2_d = s2_q + SCORE_W'(1);
          end else begin
            rr_d = RES_NONE;
          end
        end
        ST_RES_WAIT: begin
          if (cont_rise) begin
            if ((s1_q == WIN) || (s2_q == WIN)) begin
              state_d = ST_END_DRAW;
              mo_d    = 1'b1;
            end else begin
              state_d = ST_P1_DRAW;
              rr_d    = RES_NONE;
            end
          end
        end
        ST_END_DRAW: begin
          if (done_ok) state_d = ST_END_WAIT;
        end
        ST_END_WAIT: begin
          if (cont_rise) begin
            state_d = ST_TITLE_DRAW;
            s1_d    = '0;
            s2_d    = '0;
            rr_d    = RES_NONE;
            mo_d    = 1'b0;
          end
        end
        default: begin
          state_d = ST_TITLE_DRAW;
        end
      endcase
    end

    // Request is up whenever the next state is a draw state, except the cycle
    // right after a completed draw. That forces one low cycle even when a
    // restart jumps from a finished draw straight into the title draw.
    req_d = is_draw_state(state_d) & ~done_ok;

    // Screen id is chosen only when a new request rises, so it stays stable
    // for the whole handshake.
    if (req_d && !req_q) begin
      case (state_d)
        ST_TITLE_DRAW: scene_d = SCN_TITLE;
        ST_P1_DRAW:    scene_d = SCN_P1;
        ST_P2_DRAW:    scene_d = SCN_P2;
        ST_RES_DRAW:   scene_d = scenario_id(p1_d, p2_d);
        ST_END_DRAW:   scene_d = (s1_q == WIN) ? SCN_P1_WIN : SCN_P2_WIN;
        default:       scene_d = scene_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_TITLE_DRAW;
      p1_q    <= IDX_CAT;
      p2_q    <= IDX_CAT;
      s1_q    <= '0;
      s2_q    <= '0;
      rr_q    <= RES_NONE;
      mo_q    <= 1'b0;
      req_q   <= 1'b0;
      scene_q <= 4'd0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      rr_q    <= rr_d;
      mo_q    <= mo_d;
      req_q   <= req_d;
      scene_q <= scene_d;
      pend_q  <= pend_d;
    end
  end

  assign draw_req     = req_q;
  assign draw_scene   = scene_q;
  assign score1       = s1_q;
  assign score2       = s2_q;
  assign round_result = rr_q;
  assign match_over   = mo_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_round_sequencer.sv
module tb_round_sequencer;

  localparam int WIN = 5;
  localparam int SW  = 4;
  localparam int EW  = 15; // {scene[3:0], s1[3:0], s2[3:0], rr[1:0], mo}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [2:0]    choice;
  logic          choose, cont, reset_game, draw_done;
  logic          draw_req;
  logic [3:0]    draw_scene;
  logic [SW-1:0] score1, score2;
  logic [1:0]    round_result;
  logic          match_over;
  logic [3:0]    dbg_state;

  round_sequencer #(.WIN_SCORE(WIN), .SCORE_W(SW)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .choice       (choice),
    .choose       (choose),
    .cont         (cont),
    .reset_game   (reset_game),
    .draw_done    (draw_done),
    .draw_req     (draw_req),
    .draw_scene   (draw_scene),
    .score1       (score1),
    .score2       (score2),
    .round_result (round_result),
    .match_over   (match_over),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  int n_exp = 0;        // draws expected so far (driver)
  int done_cnt = 0;     // draws completed by the datapath model (responder)
  int stray_cnt = 0;    // stray done pulses asked for (driver)
  int stray_served = 0; // stray done pulses issued (responder)
  bit hold_done = 1'b0;
  int wait_cnt = 0;

  // Reference model of the game
  int m1 = 0, m2 = 0, mrr = 0, mmo = 0;
  int beats_what[3] = '{2, 0, 1}; // cat beats chicken, dog beats cat, chicken beats dog

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack(int scene, int s1, int s2, int rr, int mo);
    return {4'(scene), 4'(s1), 4'(s2), 2'(rr), 1'(mo)};
  endfunction

  function automatic int winner(int a, int b);
    if (a == b) return 0;
    if (beats_what[a] == b) return 1;
    return 2;
  endfunction

  // ---------------- datapath model (responder) ----------------
  initial begin
    draw_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      draw_done = 1'b0;
      if (stray_served != stray_cnt) begin
        stray_served++;
        if (!draw_req) draw_done = 1'b1;
      end else if (resetn && draw_req && !hold_done) begin
        if (wait_cnt == 0) begin
          draw_done = 1'b1;
          done_cnt++;
          wait_cnt = $urandom_range(0, 4);
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic          mon_prev_req = 1'b0;
  logic          mon_took = 1'b0;
  logic [3:0]    mon_scene = 4'd0;
  logic [EW-1:0] mon_e;

  always @(negedge clk) begin
    if (!resetn) begin
      mon_prev_req = 1'b0;
      mon_took = 1'b0;
    end else begin
      if (mon_took) check("req_drop_after_done", int'(draw_req), 0);
      if (draw_req && !mon_prev_req) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got scene %0d, expected no request", draw_scene);
        end else begin
          mon_e = exp_q.pop_front();
          check("scene",        int'(draw_scene),   int'(mon_e[14:11]));
          check("req_score1",   int'(score1),       int'(mon_e[10:7]));
          check("req_score2",   int'(score2),       int'(mon_e[6:3]));
          check("req_result",   int'(round_result), int'(mon_e[2:1]));
          check("req_match",    int'(match_over),   int'(mon_e[0]));
        end
        mon_scene = draw_scene;
      end else if (draw_req && mon_prev_req) begin
        check("scene_stable", int'(draw_scene), int'(mon_scene));
      end
      mon_took = draw_req && draw_done;
      mon_prev_req = draw_req;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic expect_draw(int scene);
    exp_q.push_back(pack(scene, m1, m2, mrr, mmo));
    n_exp++;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (done_cnt != n_exp && t < 300) begin
      cyc(1);
      t++;
    end
    if (done_cnt != n_exp) begin
      checks++;
      errors++;
      $display("FAIL draw_timeout: got %0d draws done, expected %0d", done_cnt, n_exp);
    end
    cyc(3);
  endtask

  task automatic press_cont(int hold);
    cont = 1'b1;
    cyc(hold);
    cont = 1'b0;
    cyc(1);
  endtask

  task automatic press_choose(logic [2:0] c, int hold);
    choice = c;
    choose = 1'b1;
    cyc(hold);
    choose = 1'b0;
    cyc(1);
  endtask

  // From P1_PICK: both picks, then check the round outcome in RES_WAIT.
  task automatic play_picks(int a, int b, int hold);
    int w;
    expect_draw(11);
    press_choose(3'(1 << a), hold);
    wait_idle();
    expect_draw(a * 3 + b);
    press_choose(3'(1 << b), 1);
    wait_idle();
    w = winner(a, b);
    if (w == 1) begin
      mrr = 1;
      if (m1 < WIN) m1++;
    end else if (w == 2) begin
      mrr = 2;
      if (m2 < WIN) m2++;
    end else begin
      mrr = 0;
    end
    check("round_result", int'(round_result), mrr);
    check("score1", int'(score1), m1);
    check("score2", int'(score2), m2);
  endtask

  // From RES_WAIT: continue to the next round, or through the end of match
  // and a fresh start, ending in P1_PICK.
  task automatic advance();
    if (m1 == WIN || m2 == WIN) begin
      mmo = 1;
      expect_draw(m1 == WIN ? 12 : 13);
      press_cont(1);
      wait_idle();
      check("match_over_end", int'(match_over), 1);
      m1 = 0; m2 = 0; mrr = 0; mmo = 0;
      expect_draw(9);
      press_cont(2);
      wait_idle();
      check("score1_cleared", int'(score1), 0);
      check("score2_cleared", int'(score2), 0);
      check("match_over_cleared", int'(match_over), 0);
      expect_draw(10);
      press_cont(1);
      wait_idle();
    end else begin
      mrr = 0;
      expect_draw(10);
      press_cont(1);
      wait_idle();
    end
  endtask

  task automatic play_round(int a, int b, int hold);
    play_picks(a, b, hold);
    advance();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  logic [2:0] invalids[4] = '{3'b000, 3'b011, 3'b110, 3'b111};

  initial begin
    resetn = 1'b0;
    choice = 3'b000;
    choose = 1'b0;
    cont = 1'b0;
    reset_game = 1'b0;
    cyc(3);
    check("rst_draw_req", int'(draw_req), 0);
    check("rst_draw_scene", int'(draw_scene), 0);
    check("rst_score1", int'(score1), 0);
    check("rst_score2", int'(score2), 0);
    check("rst_result", int'(round_result), 0);
    check("rst_match_over", int'(match_over), 0);

    expect_draw(9);
    resetn = 1'b1;
    cyc(1);
    check("req_after_reset", int'(draw_req), 1);
    check("scene_after_reset", int'(draw_scene), 9);
    wait_idle();

    // WAIT_START: choose is not consumed, stray done ignored, no request
    press_choose(3'b010, 1);
    stray_cnt++;
    cyc(6);
    check("idle_no_req", int'(draw_req), 0);

    expect_draw(10);
    press_cont(2);
    wait_idle();

    // Invalid choices in P1_PICK are ignored
    press_choose(3'b011, 1);
    press_choose(3'b000, 1);
    cyc(4);
    check("invalid_choice_no_req", int'(draw_req), 0);

    play_round(1, 0, 1);  // dog vs cat: P1 wins, scene 3
    play_round(0, 0, 9);  // cat vs cat: tie, long held choose
    for (int i = 0; i < 5; i++) play_round(1, 2, 1); // chicken beats dog

    // Random rounds
    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 3) == 0) press_choose(invalids[$urandom_range(0, 3)], 1);
      play_round($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(1, 4));
    end

    // Restart together with a valid choose in P1_PICK: restart wins
    m1 = 0; m2 = 0; mrr = 0; mmo = 0;
    expect_draw(9);
    reset_game = 1'b1;
    choice = 3'b001;
    choose = 1'b1;
    cyc(1);
    reset_game = 1'b0;
    choose = 1'b0;
    cyc(1);
    wait_idle();
    expect_draw(10);
    press_cont(1);
    wait_idle();

    // Restart while the P1 prompt draw is outstanding
    play_picks(0, 2, 1);  // cat beats chicken: score1 = 1
    hold_done = 1'b1;
    mrr = 0;
    expect_draw(10);
    press_cont(1);
    cyc(3);
    reset_game = 1'b1;
    choice = 3'b010;
    choose = 1'b1;
    cyc(1);
    reset_game = 1'b0;
    choose = 1'b0;
    cyc(6);
    check("held_req", int'(draw_req), 1);
    check("held_scene", int'(draw_scene), 10);
    check("held_score1", int'(score1), m1);
    m1 = 0; m2 = 0; mrr = 0; mmo = 0;
    expect_draw(9);
    hold_done = 1'b0;
    wait_idle();
    check("restart_score1", int'(score1), 0);
    expect_draw(10);
    press_cont(1);
    wait_idle();
    play_round(2, 1, 1);  // chicken beats dog: P1 wins

    cyc(10);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
